// File: rtl/serv_mtimer_pkg.sv
// Shared definitions for the machine timer: register word offsets, legal widths and
// the byte-lane write merge used for every register.
package serv_mtimer_pkg;

  localparam logic [1:0] MTIME_LO    = 2'd0;
  localparam logic [1:0] MTIME_HI    = 2'd1;
  localparam logic [1:0] MTIMECMP_LO = 2'd2;
  localparam logic [1:0] MTIMECMP_HI = 2'd3;

  localparam int unsigned WIDTH_32 = 32;
  localparam int unsigned WIDTH_64 = 64;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  sel);
    logic [31:0] merged;
    merged = old_word;
    for (int n = 0; n < 4; n++) begin
      if (sel[n]) merged[8*n +: 8] = wdata[8*n +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/serv_mtimer_if.sv
// Wishbone slave bus between the SoC data bus and the machine timer.
interface serv_mtimer_if;

  logic [1:0]  adr;
  logic [31:0] dat;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic [31:0] rdt;
  logic        ack;

  modport master (output adr, dat, sel, we, cyc, stb, input rdt, ack);
  modport slave  (input adr, dat, sel, we, cyc, stb, output rdt, ack);

endinterface

// File: rtl/serv_mtimer_prescale.sv
// mtime prescaler: counts 0..PRESCALER-1 and pulses tick on the terminal count.
module serv_mtimer_prescale #(
  parameter int unsigned PRESCALER = 1,
  parameter bit          RESET_EN  = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_tick
);

  if (PRESCALER <= 1) begin : gen_every_cycle
    logic unused_clk_rst;
    assign unused_clk_rst = i_clk ^ i_rst;
    assign o_tick = 1'b1;
  end else begin : gen_count
    localparam int unsigned CntW = $clog2(PRESCALER);

    logic [CntW-1:0] cnt_q;

    assign o_tick = (cnt_q == CntW'(PRESCALER - 1));

    always_ff @(posedge i_clk) begin
      if (i_rst && RESET_EN) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= o_tick ? '0 : cnt_q + CntW'(1);
      end
    end
  end

endmodule

// File: rtl/serv_mtimer.sv
// Machine timer (mtime/mtimecmp) behind a 32-bit Wishbone slave; drives the level
// timer-interrupt request o_mtip.
module serv_mtimer
  import serv_mtimer_pkg::*;
#(
  parameter string       RESET_STRATEGY = "MINI",
  parameter int unsigned WIDTH          = 64,
  parameter int unsigned PRESCALER      = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  serv_mtimer_if.slave wb,
  output logic         o_mtip
);

  localparam bit ResetEn = (RESET_STRATEGY != "NONE");
  localparam bit Wide    = (WIDTH == WIDTH_64);

  logic             tick;
  logic             req;
  logic             ack_q;
  logic             mtip_q;
  logic [WIDTH-1:0] mtime_q, mtime_d;
  logic [WIDTH-1:0] mtimecmp_q, mtimecmp_d;
  logic [63:0]      mtime_x, cmp_x, mtime_nx, cmp_nx;
  logic [31:0]      snap_q, snap_d;
  logic [31:0]      rdt_q, rdt_d;

  serv_mtimer_prescale #(
    .PRESCALER (PRESCALER),
    .RESET_EN  (ResetEn)
  ) u_prescale (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .o_tick (tick)
  );

  assign req     = wb.cyc & wb.stb & ~ack_q;
  assign mtime_x = 64'(mtime_q);
  assign cmp_x   = 64'(mtimecmp_q);

  // Work on zero-extended 64-bit views so the same decode serves both widths.
  always_comb begin
    mtime_nx = mtime_x;
    cmp_nx   = cmp_x;
    snap_d   = snap_q;
    rdt_d    = rdt_q;
    if (tick) mtime_nx = 64'(mtime_q + WIDTH'(1));

    if (req && wb.we) begin
      // A write to mtime replaces the whole next value, so it also swallows the tick.
      unique case (wb.adr)
        MTIME_LO: mtime_nx = {mtime_x[63:32], byte_merge(mtime_x[31:0], wb.dat, wb.sel)};
        MTIME_HI: begin
          if (Wide) begin
            mtime_nx = {byte_merge(mtime_x[63:32], wb.dat, wb.sel), mtime_x[31:0]};
            snap_d   = mtime_nx[63:32];
          end
        end
        MTIMECMP_LO: cmp_nx[31:0] = byte_merge(cmp_x[31:0], wb.dat, wb.sel);
        MTIMECMP_HI: begin
          if (Wide) cmp_nx[63:32] = byte_merge(cmp_x[63:32], wb.dat, wb.sel);
        end
        default: ;
      endcase
    end else if (req) begin
      unique case (wb.adr)
        MTIME_LO: begin
          rdt_d = mtime_nx[31:0];
          if (Wide) snap_d = mtime_nx[63:32];
        end
        MTIME_HI:    rdt_d = Wide ? snap_q : '0;
        MTIMECMP_LO: rdt_d = cmp_x[31:0];
        MTIMECMP_HI: rdt_d = cmp_x[63:32];
        default: ;
      endcase
    end
  end

  assign mtime_d    = WIDTH'(mtime_nx);
  assign mtimecmp_d = WIDTH'(cmp_nx);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ack_q <= 1'b0;
      if (ResetEn) begin
        mtime_q    <= '0;
        mtimecmp_q <= '1;
        rdt_q      <= '0;
        mtip_q     <= 1'b0;
      end
    end else begin
      ack_q      <= req;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      rdt_q      <= rdt_d;
      mtip_q     <= (mtime_q >= mtimecmp_q);
    end
  end

  if (Wide) begin : gen_snap
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        if (ResetEn) snap_q <= '0;
      end else begin
        snap_q <= snap_d;
      end
    end
  end else begin : gen_no_snap
    logic unused_snap;
    assign unused_snap = ^snap_d;
    assign snap_q      = '0;
  end

  assign wb.rdt = rdt_q;
  assign wb.ack = ack_q;
  assign o_mtip = mtip_q;

endmodule

// File: tb/tb_serv_mtimer.sv
// Bench for serv_mtimer: three builds (64-bit/P1, 64-bit/P4, 32-bit/P3) against a
// cycle-level arithmetic model; table vectors, corner sequences, then random traffic.
module tb_serv_mtimer;
  import serv_mtimer_pkg::*;

  localparam int NDUT = 3;
  localparam int unsigned PRE [NDUT] = '{1, 4, 3};
  localparam int unsigned WID [NDUT] = '{64, 64, 32};

  logic        clk = 1'b0;
  logic        rst_a [NDUT];
  logic [1:0]  adr_a [NDUT];
  logic [31:0] dat_a [NDUT];
  logic [3:0]  sel_a [NDUT];
  logic        we_a  [NDUT];
  logic        cyc_a [NDUT];
  logic        stb_a [NDUT];
  logic [31:0] rdt_a [NDUT];
  logic        ack_a [NDUT];
  logic        mtip_a[NDUT];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serv_mtimer_if bus [NDUT] ();

  for (genvar g = 0; g < NDUT; g++) begin : gen_dut
    assign bus[g].adr = adr_a[g];
    assign bus[g].dat = dat_a[g];
    assign bus[g].sel = sel_a[g];
    assign bus[g].we  = we_a[g];
    assign bus[g].cyc = cyc_a[g];
    assign bus[g].stb = stb_a[g];
    assign rdt_a[g]   = bus[g].rdt;
    assign ack_a[g]   = bus[g].ack;

    serv_mtimer #(
      .RESET_STRATEGY ("MINI"),
      .WIDTH          (WID[g]),
      .PRESCALER      (PRE[g])
    ) u_dut (
      .i_clk  (clk),
      .i_rst  (rst_a[g]),
      .wb     (bus[g]),
      .o_mtip (mtip_a[g])
    );
  end

  // Reference model: state of one timer as plain numbers.
  typedef struct {
    longint unsigned mtime;
    longint unsigned cmp;
    longint unsigned snap;
    int unsigned     phase;
    bit              ack;
    bit              rd;
    bit              mtip;
    logic [31:0]     rdt;
  } mstate_t;

  mstate_t m [NDUT];

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] d,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old_w;
    for (int n = 0; n < 4; n++) if (sel[n]) r[8*n +: 8] = d[8*n +: 8];
    return r;
  endfunction

  function automatic mstate_t step(input mstate_t s, input int k, input bit rst, input bit cyc,
                                   input bit stb, input bit we, input logic [1:0] adr,
                                   input logic [3:0] sel, input logic [31:0] dat);
    mstate_t         n;
    bit              w64;
    bit              req;
    bit              tick;
    longint unsigned mask;
    logic [31:0]     hi;
    n    = s;
    w64  = (WID[k] == 64);
    mask = w64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    if (rst) begin
      n.mtime = 0; n.cmp = mask; n.snap = 0; n.phase = 0;
      n.ack = 1'b0; n.rd = 1'b0; n.mtip = 1'b0; n.rdt = '0;
      return n;
    end
    req     = cyc && stb && !s.ack;
    tick    = (s.phase == PRE[k] - 1);
    n.phase = tick ? 0 : s.phase + 1;
    n.mtip  = (s.mtime >= s.cmp);
    n.ack   = req;
    n.rd    = req && !we;
    if (tick) n.mtime = (s.mtime + 1) & mask;
    if (req && we) begin
      case (adr)
        2'd0: n.mtime = {s.mtime[63:32], merge(s.mtime[31:0], dat, sel)};
        2'd1: if (w64) begin
          hi      = merge(s.mtime[63:32], dat, sel);
          n.mtime = {hi, s.mtime[31:0]};
          n.snap  = hi;
        end
        2'd2: n.cmp = {s.cmp[63:32], merge(s.cmp[31:0], dat, sel)};
        default: if (w64) n.cmp = {merge(s.cmp[63:32], dat, sel), s.cmp[31:0]};
      endcase
    end else if (req) begin
      case (adr)
        2'd0: begin
          n.rdt = n.mtime[31:0];
          if (w64) n.snap = n.mtime[63:32];
        end
        2'd1:    n.rdt = w64 ? s.snap[31:0] : 32'd0;
        2'd2:    n.rdt = s.cmp[31:0];
        default: n.rdt = w64 ? s.cmp[63:32] : 32'd0;
      endcase
    end
    return n;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < NDUT; k++) begin
      m[k] <= step(m[k], k, rst_a[k], cyc_a[k], stb_a[k], we_a[k], adr_a[k], sel_a[k], dat_a[k]);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: got timeout, want event", name);
  endtask

  // One bus transfer, started and finished on a falling edge.
  task automatic xfer(input int k, input bit we, input logic [1:0] adr, input logic [3:0] sel,
                      input logic [31:0] dat, input bit hold, output logic [31:0] rd);
    bit got;
    got = 1'b0;
    rd  = '0;
    adr_a[k] = adr; dat_a[k] = dat; sel_a[k] = sel; we_a[k] = we;
    cyc_a[k] = 1'b1; stb_a[k] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack_a[k] === 1'b1) begin
        rd  = rdt_a[k];
        got = 1'b1;
        break;
      end
    end
    if (!got) fail_now($sformatf("ack[%0d]", k));
    if (hold) @(negedge clk);
    cyc_a[k] = 1'b0; stb_a[k] = 1'b0; we_a[k] = 1'b0;
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      for (int k = 0; k < NDUT; k++) begin
        check($sformatf("ack[%0d]", k), 64'(ack_a[k]), 64'(m[k].ack));
        check($sformatf("mtip[%0d]", k), 64'(mtip_a[k]), 64'(m[k].mtip));
        if (m[k].ack && m[k].rd) check($sformatf("rdt[%0d]", k), 64'(rdt_a[k]), 64'(m[k].rdt));
      end
    end
  endtask

  task automatic rand_run(input int k, input int count);
    logic [31:0] rd;
    logic [31:0] d;
    logic [3:0]  s;
    for (int i = 0; i < count; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if ($urandom_range(0, 99) == 0) begin
        rst_a[k] = 1'b1;
        @(negedge clk);
        rst_a[k] = 1'b0;
      end
      case ($urandom_range(0, 2))
        0:       d = $urandom;
        1:       d = 32'($urandom_range(0, 40));
        default: d = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      endcase
      s = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      xfer(k, 1'($urandom), 2'($urandom_range(0, 3)), s, d, ($urandom_range(0, 3) == 0), rd);
    end
  endtask

  typedef struct {
    bit          we;
    logic [1:0]  adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [12];

  initial begin
    logic [31:0] rd, lo, hi;
    bit          found;

    tbl[0]  = '{1'b1, MTIMECMP_HI, 4'hF, 32'hFFFF_FFFF, 32'h0};
    tbl[1]  = '{1'b1, MTIMECMP_LO, 4'hF, 32'h1122_3344, 32'h0};
    tbl[2]  = '{1'b0, MTIMECMP_LO, 4'hF, 32'h0,         32'h1122_3344};
    tbl[3]  = '{1'b1, MTIMECMP_LO, 4'b0100, 32'h00AB_0000, 32'h0};
    tbl[4]  = '{1'b0, MTIMECMP_LO, 4'hF, 32'h0,         32'h11AB_3344};
    tbl[5]  = '{1'b1, MTIMECMP_LO, 4'b0001, 32'hFFFF_FFCD, 32'h0};
    tbl[6]  = '{1'b1, MTIMECMP_LO, 4'b1010, 32'hA1B2_C3D4, 32'h0};
    tbl[7]  = '{1'b0, MTIMECMP_LO, 4'hF, 32'h0,         32'hA1AB_C3CD};
    tbl[8]  = '{1'b1, MTIMECMP_HI, 4'b0011, 32'h0000_1234, 32'h0};
    tbl[9]  = '{1'b0, MTIMECMP_HI, 4'hF, 32'h0,         32'hFFFF_1234};
    tbl[10] = '{1'b1, MTIMECMP_LO, 4'b0000, 32'h0,      32'h0};
    tbl[11] = '{1'b0, MTIMECMP_LO, 4'hF, 32'h0,         32'hA1AB_C3CD};

    for (int k = 0; k < NDUT; k++) begin
      rst_a[k] = 1'b1; adr_a[k] = '0; dat_a[k] = '0; sel_a[k] = '0;
      we_a[k] = 1'b0; cyc_a[k] = 1'b0; stb_a[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    fork monitor(); join_none
    for (int k = 0; k < NDUT; k++) rst_a[k] = 1'b0;

    // Free-running after reset; the read returns mtime as it stands after its ack edge.
    repeat (10) @(negedge clk);
    check("idle mtip", 64'(mtip_a[0]), 64'd0);
    xfer(0, 1'b0, MTIME_LO, 4'hF, 32'h0, 1'b0, rd);
    check("idle mtime_lo", 64'(rd), 64'h0B);

    // Compare match and clear.
    xfer(0, 1'b1, MTIME_LO, 4'hF, 32'h0, 1'b0, rd);
    xfer(0, 1'b1, MTIMECMP_HI, 4'hF, 32'h0, 1'b0, rd);
    xfer(0, 1'b1, MTIMECMP_LO, 4'hF, 32'd20, 1'b0, rd);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (m[0].mtime == 20) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!found) fail_now("mtime reach 20");
    check("mtip at mtime==cmp", 64'(mtip_a[0]), 64'd0);
    @(negedge clk);
    check("mtip one cycle later", 64'(mtip_a[0]), 64'd1);
    xfer(0, 1'b1, MTIMECMP_LO, 4'hF, 32'hFFFF_FFFF, 1'b0, rd);
    xfer(0, 1'b1, MTIMECMP_HI, 4'hF, 32'hFFFF_FFFF, 1'b0, rd);
    @(negedge clk);
    check("mtip cleared", 64'(mtip_a[0]), 64'd0);

    // Tear-free 64-bit read across the low-word wrap.
    xfer(0, 1'b1, MTIME_HI, 4'hF, 32'h0, 1'b0, rd);
    xfer(0, 1'b1, MTIME_LO, 4'hF, 32'hFFFF_FFFE, 1'b0, rd);
    xfer(0, 1'b0, MTIME_LO, 4'hF, 32'h0, 1'b0, lo);
    xfer(0, 1'b0, MTIME_HI, 4'hF, 32'h0, 1'b0, hi);
    check("snapshot hi vs lo", 64'(hi), (lo >= 32'hFFFF_FFFE) ? 64'd0 : 64'd1);
    xfer(0, 1'b0, MTIME_LO, 4'hF, 32'h0, 1'b0, lo);
    xfer(0, 1'b0, MTIME_HI, 4'hF, 32'h0, 1'b0, hi);
    check("hi after wrap", 64'(hi), 64'd1);
    check("lo after wrap small", 64'(lo < 32'd16), 64'd1);

    // Prescaler 4: a write keeps the tick phase and beats a coinciding tick.
    xfer(1, 1'b1, MTIME_HI, 4'hF, 32'h0, 1'b0, rd);
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (m[1].phase == 1) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!found) fail_now("phase 1");
    xfer(1, 1'b1, MTIME_LO, 4'hF, 32'h0, 1'b0, rd);
    xfer(1, 1'b0, MTIME_LO, 4'hF, 32'h0, 1'b0, rd);
    check("phase kept after write", 64'(rd), 64'd1);
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (m[1].phase == 3) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!found) fail_now("phase 3");
    xfer(1, 1'b1, MTIME_LO, 4'hF, 32'h100, 1'b0, rd);
    xfer(1, 1'b0, MTIME_LO, 4'hF, 32'h0, 1'b0, rd);
    check("write on tick wins", 64'(rd), 64'h100);

    // Byte-lane table.
    foreach (tbl[i]) begin
      xfer(0, tbl[i].we, tbl[i].adr, tbl[i].sel, tbl[i].dat, 1'b0, rd);
      if (!tbl[i].we) check($sformatf("table[%0d]", i), 64'(rd), 64'(tbl[i].exp));
    end

    // Reset while a write to mtime_lo is on the bus.
    rst_a[0] = 1'b1;
    adr_a[0] = MTIME_LO; dat_a[0] = 32'h5555; sel_a[0] = 4'hF;
    we_a[0] = 1'b1; cyc_a[0] = 1'b1; stb_a[0] = 1'b1;
    @(negedge clk);
    check("ack under reset", 64'(ack_a[0]), 64'd0);
    rst_a[0] = 1'b0;
    xfer(0, 1'b0, MTIME_LO, 4'hF, 32'h0, 1'b0, rd);
    check("write discarded by reset", 64'(rd), 64'd1);

    // 32-bit build: upper words absent, compare on 32 bits.
    xfer(2, 1'b1, MTIME_HI, 4'hF, 32'hFFFF_FFFF, 1'b0, rd);
    xfer(2, 1'b0, MTIME_HI, 4'hF, 32'h0, 1'b0, rd);
    check("w32 mtime_hi", 64'(rd), 64'd0);
    xfer(2, 1'b1, MTIMECMP_HI, 4'hF, 32'hFFFF_FFFF, 1'b0, rd);
    xfer(2, 1'b0, MTIMECMP_HI, 4'hF, 32'h0, 1'b0, rd);
    check("w32 mtimecmp_hi", 64'(rd), 64'd0);
    xfer(2, 1'b1, MTIME_LO, 4'hF, 32'h0, 1'b0, rd);
    xfer(2, 1'b1, MTIMECMP_LO, 4'hF, 32'h10, 1'b0, rd);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (m[2].mtime >= 16) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!found) fail_now("w32 mtime reach cmp");
    @(negedge clk);
    check("w32 mtip", 64'(mtip_a[2]), 64'd1);

    fork
      rand_run(0, 300);
      rand_run(1, 300);
      rand_run(2, 300);
    join
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
